// File: rtl/cache_mem_arb_pkg.sv
// Shared types and constants for the I/D cache to memory arbiter.
// State and owner encodings are fixed so traces read the same across builds.
package cache_mem_arb_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_LINE_W   = 256;
  localparam int DEF_MAX_WAIT = 64;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    DONE = S_DONE
  } state_e;

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// Two-way round-robin pick between the I and D miss ports.
// On a tie the requester that was not granted last wins.
module rr_arbiter2
  import cache_mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_owner_o
);

  always_comb begin
    gnt_valid_o = i_req_i | d_req_i;
    gnt_owner_o = OWN_I;
    if (i_req_i && d_req_i) begin
      gnt_owner_o = ~last_grant_i;
    end else if (d_req_i) begin
      gnt_owner_o = OWN_D;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache fills and D-cache fills/write-backs onto one memory port,
// one line per transaction, with a watchdog bounding each memory wait.
module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINE_W   = DEF_LINE_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [LINE_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              timeout_o
);

  localparam int              WD_W    = $clog2(MAX_WAIT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              timeout_q, timeout_d;

  logic gnt_valid;
  logic gnt_owner;

  rr_arbiter2 u_rr (
    .i_req_i      (i_req_i),
    .d_req_i      (d_req_i),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_owner_o  (gnt_owner)
  );

  // Ack is registered on the BUSY->DONE edge so it is visible during DONE,
  // letting the requester drop req before the next IDLE samples it.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d   = gnt_owner;
          mem_req_d = 1'b1;
          wd_d      = '0;
          state_d   = BUSY;
          if (gnt_owner == OWN_D) begin
            mem_addr_d  = d_addr_i;
            mem_we_d    = d_we_i;
            mem_wdata_d = d_wdata_i;
          end else begin
            mem_addr_d  = i_addr_i;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
          end
        end
      end

      BUSY: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          wd_d      = '0;
          state_d   = DONE;
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rdata_i;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = mem_rdata_i;
            i_ack_d   = 1'b1;
          end
        end else if (wd_q == WD_LAST) begin
          // Expired: still complete the requester, but with a zero line.
          mem_req_d = 1'b0;
          wd_d      = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
          if (owner_q == OWN_D) begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = '0;
            i_ack_d   = 1'b1;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_D;
      wd_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign i_ack_o     = i_ack_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign timeout_o   = timeout_q;

endmodule
